// File: rtl/reg_writeback_queue.sv
// In-order writeback queue: two producers enqueue results, which drain onto a
// two-port register file, with a combinational forwarding lookup over queued entries.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module reg_writeback_queue #(
    parameter int SIZE  = 16,
    parameter int WIDTH = `WORD_LENGTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inValidA,
    output logic                       inReadyA,
    input  logic [$clog2(SIZE)-1:0]    inAddrA,
    input  logic [WIDTH-1:0]           inDataA,
    input  logic                       inValidB,
    output logic                       inReadyB,
    input  logic [$clog2(SIZE)-1:0]    inAddrB,
    input  logic [WIDTH-1:0]           inDataB,
    input  logic                       drainEnable,
    output logic                       writeEnable1,
    output logic [$clog2(SIZE)-1:0]    writeAddr1,
    output logic [WIDTH-1:0]           writeData1,
    output logic                       writeEnable2,
    output logic [$clog2(SIZE)-1:0]    writeAddr2,
    output logic [WIDTH-1:0]           writeData2,
    input  logic [$clog2(SIZE)-1:0]    lookupAddr,
    output logic                       lookupHit,
    output logic [WIDTH-1:0]           lookupData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(SIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head, tail, head1, idx;
    logic [CW-1:0]    count_q, free, retire, nstore;
    logic             ent_valid [DEPTH];
    logic [AW-1:0]    ent_addr  [DEPTH];
    logic [WIDTH-1:0] ent_data  [DEPTH];
    logic             store_a, store_b;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign free     = CW'(DEPTH) - count_q;
    assign inReadyA = (free >= CW'(1));
    assign inReadyB = (free >= CW'(2));
    assign head1    = head + PW'(1);

    // Register 0 writes complete the handshake but never occupy a slot.
    assign store_a = inValidA && inReadyA && (inAddrA != '0);
    assign store_b = inValidB && inReadyB && (inAddrB != '0);
    assign nstore  = CW'(store_a) + CW'(store_b);

    always_comb begin
        writeEnable1 = 1'b0;
        writeAddr1   = '0;
        writeData1   = '0;
        writeEnable2 = 1'b0;
        writeAddr2   = '0;
        writeData2   = '0;
        retire       = '0;
        if (drainEnable && count_q != '0) begin
            if (count_q == CW'(1)) begin
                writeEnable1 = 1'b1;
                writeAddr1   = ent_addr[head];
                writeData1   = ent_data[head];
                retire       = CW'(1);
            end else if (ent_addr[head] != ent_addr[head1]) begin
                writeEnable1 = 1'b1;
                writeAddr1   = ent_addr[head];
                writeData1   = ent_data[head];
                writeEnable2 = 1'b1;
                writeAddr2   = ent_addr[head1];
                writeData2   = ent_data[head1];
                retire       = CW'(2);
            end else begin
                // Same destination: the younger value supersedes, older is dropped.
                writeEnable1 = 1'b1;
                writeAddr1   = ent_addr[head1];
                writeData1   = ent_data[head1];
                retire       = CW'(2);
            end
        end
    end

    always_comb begin
        lookupHit  = 1'b0;
        lookupData = '0;
        idx        = '0;
        if (lookupAddr != '0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if (i < 32'(count_q) && ent_valid[idx] && ent_addr[idx] == lookupAddr) begin
                    lookupHit  = 1'b1;
                    lookupData = ent_data[idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_valid[i] <= 1'b0;
                ent_addr[i]  <= '0;
                ent_data[i]  <= '0;
            end
        end else begin
            if (retire != '0) ent_valid[head] <= 1'b0;
            if (retire == CW'(2)) ent_valid[head1] <= 1'b0;
            if (store_a) begin
                ent_valid[tail] <= 1'b1;
                ent_addr[tail]  <= inAddrA;
                ent_data[tail]  <= inDataA;
            end
            if (store_b) begin
                ent_valid[tail + PW'(store_a)] <= 1'b1;
                ent_addr[tail + PW'(store_a)]  <= inAddrB;
                ent_data[tail + PW'(store_a)]  <= inDataB;
            end
            head    <= head + PW'(retire);
            tail    <= tail + PW'(nstore);
            count_q <= count_q + nstore - retire;
        end
    end
endmodule
